write_back_stage: RTL
=====================

Name: write_back_stage

Overview:
- Write-back stage sitting directly downstream of the memory stage in the Y86 datapath.
- Consumes valE, valM and stat from the memory stage and commits results into the 15-entry architectural register file.
- Provides the decode-side read ports with write-through bypass.
- Owns the processor run/halt/fault state machine and a retired-instruction counter.

Parameters:
- DATA_WID, 64, register/data width in bits
- REG_ID_WID, 4, register identifier width
- NUM_REGS, 15, architectural registers (ids 0..14; id 15 = RNONE)
- CNT_WID, 32, retired-instruction counter width

Ports:
- CLK  in  1  system clock, all state updates on rising edge
- RST_N  in  1  synchronous active-low reset
- wb_valid  in  1  memory stage presents an instruction this cycle
- icode  in  4  instruction code of presented instruction
- stat_in  in  4  status from memory stage (AOK=1, HLT=2, ADR=3, INS=4)
- dstE  in  REG_ID_WID  destination for valE (RNONE = no write)
- dstM  in  REG_ID_WID  destination for valM (RNONE = no write)
- valE  in  DATA_WID  ALU result
- valM  in  DATA_WID  memory read data
- srcA  in  REG_ID_WID  decode read port A id
- srcB  in  REG_ID_WID  decode read port B id
- valA_out  out  DATA_WID  read data A (combinational)
- valB_out  out  DATA_WID  read data B (combinational)
- cpu_stat  out  4  registered processor status
- halted  out  1  high when state is not RUN
- retired_cnt  out  CNT_WID  count of retired instructions

Behaviour:
- Clock is CLK. Reset is synchronous and active-low on RST_N. Reset has priority over all other inputs in the same edge.
- Reset values: all registers 0, state RUN, cpu_stat=AOK(1), halted=0, retired_cnt=0.
- The reset value of valA_out/valB_out follows from the read rules below (0 after reset).
- FSM states: RUN, HALTED, FAULT.
- RUN, wb_valid=0: no change.
- RUN, wb_valid=1, stat_in=AOK:
  - write valE to dstE if dstE≠RNONE;
  - write valM to dstM if dstM≠RNONE;
  - if dstE==dstM≠RNONE, valM wins;
  - retired_cnt+1.
- RUN, wb_valid=1, stat_in=HLT: no register writes; retired_cnt+1; cpu_stat←HLT; next state HALTED.
- RUN, wb_valid=1, stat_in=ADR or INS: no register writes; retired_cnt unchanged; cpu_stat←stat_in; next state FAULT.
- RUN, wb_valid=1, any other stat_in value (0, 5..15): treated as INS; cpu_stat←INS; next state FAULT.
- HALTED/FAULT: all write inputs ignored; cpu_stat and retired_cnt frozen. Only RST_N low returns to RUN.
- halted = (state≠RUN), registered; it rises in the cycle after the terminating instruction.
- Read ports:
  - Combinational.
  - srcX==RNONE returns 0.
  - Otherwise returns the register contents, with write-through bypass: if a write to srcX is being committed this cycle, return the write value (dstM match has priority over dstE match).
  - Bypass is inactive when no write is committed (wb_valid=0, stat_in≠AOK, or state≠RUN).
- retired_cnt wraps from 2^CNT_WID−1 to 0, with no saturation or flag.
- icode is informational only. Commit decisions depend solely on wb_valid, stat_in, dstE and dstM. RNONE on both destinations (e.g. nop, jXX) retires with no writes.
- Reset asserted while a write is presented: reset wins, the write is dropped, and all registers read 0 next cycle.
- Latency: write committed at the rising edge of the presenting cycle, visible in storage from the next cycle and to the same-cycle reader via bypass.

Decomposition:
- Shared header additions:
  - stat codes SAOK/SHLT/SADR/SINS;
  - RNONE=4'hF;
  - register id constants RRAX..R14;
  - FSM state encoding WB_RUN/WB_HALTED/WB_FAULT;
  - CNT_WID default.
- One sub-module, reg_file: 15×DATA_WID storage, two write ports with M-priority, two combinational read ports with bypass. It has write-enable inputs and no FSM knowledge.
- write_back_stage holds the FSM, the commit-enable logic, the counter and the reg_file instance.

Test Plan:
- Reset then read all ids 0..15 -> all return 0; cpu_stat=1, halted=0, retired_cnt=0.
- wb_valid=1, AOK, dstE=0 valE=0x1234, dstM=3 valM=0xABCD, srcA=0, srcB=3 same cycle -> valA_out=0x1234, valB_out=0xABCD via bypass; next cycle storage holds the same values; retired_cnt=1.
- dstE=dstM=4, valE=0x10, valM=0x20, AOK -> reg4=0x20; same-cycle srcA=4 reads 0x20.
- AOK write to reg2=0x5, then stat_in=HLT with dstE=2 valE=0x99 -> reg2 stays 0x5; cpu_stat=2, halted=1, retired_cnt=2; subsequent AOK writes ignored.
- stat_in=ADR -> cpu_stat=3, halted=1, retired_cnt unchanged, no writes; separately stat_in=7 -> cpu_stat=4; RST_N low one cycle -> RUN, cpu_stat=1, registers 0.
- Preload retired_cnt near wrap (CNT_WID=4 build, 15 AOK retires then 1 more) -> counter reads 15 then 0.

Source files
------------

// File: rtl/write_back_stage_pkg.sv
// Shared definitions for the Y86 write-back stage: status codes, register ids,
// FSM state encoding and default widths.
package write_back_stage_pkg;

  localparam int DATA_WID_DEF   = 64;
  localparam int REG_ID_WID_DEF = 4;
  localparam int NUM_REGS_DEF   = 15;
  localparam int CNT_WID_DEF    = 32;

  // Processor status codes carried down the pipeline.
  typedef enum logic [3:0] {
    SAOK = 4'h1,
    SHLT = 4'h2,
    SADR = 4'h3,
    SINS = 4'h4
  } stat_t;

  // Register identifier meaning "no register".
  localparam logic [3:0] RNONE = 4'hF;

  // Architectural register ids.
  localparam logic [3:0] RRAX = 4'h0;
  localparam logic [3:0] RRCX = 4'h1;
  localparam logic [3:0] RRDX = 4'h2;
  localparam logic [3:0] RRBX = 4'h3;
  localparam logic [3:0] RRSP = 4'h4;
  localparam logic [3:0] RRBP = 4'h5;
  localparam logic [3:0] RRSI = 4'h6;
  localparam logic [3:0] RRDI = 4'h7;
  localparam logic [3:0] R8   = 4'h8;
  localparam logic [3:0] R9   = 4'h9;
  localparam logic [3:0] R10  = 4'hA;
  localparam logic [3:0] R11  = 4'hB;
  localparam logic [3:0] R12  = 4'hC;
  localparam logic [3:0] R13  = 4'hD;
  localparam logic [3:0] R14  = 4'hE;

  // Run / halt / fault state of the processor.
  typedef enum logic [1:0] {
    WB_RUN    = 2'd0,
    WB_HALTED = 2'd1,
    WB_FAULT  = 2'd2
  } wb_state_t;

  // Status recorded on a faulting instruction: ADR is kept, anything
  // else that is neither AOK nor HLT is reported as an invalid instruction.
  function automatic logic [3:0] fault_code(input logic [3:0] stat);
    return (stat == SADR) ? SADR : SINS;
  endfunction

endpackage

// File: rtl/write_back_stage_reg_file.sv
// Architectural register file: two write ports (M port wins on a shared
// destination) and two combinational read ports with write-through bypass.
// Knows nothing about processor state; callers gate the write enables.
module reg_file
  import write_back_stage_pkg::*;
#(
  parameter int DATA_WID   = DATA_WID_DEF,
  parameter int REG_ID_WID = REG_ID_WID_DEF,
  parameter int NUM_REGS   = NUM_REGS_DEF
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  we_e,
  input  logic [REG_ID_WID-1:0] dst_e,
  input  logic [DATA_WID-1:0]   val_e,
  input  logic                  we_m,
  input  logic [REG_ID_WID-1:0] dst_m,
  input  logic [DATA_WID-1:0]   val_m,
  input  logic [REG_ID_WID-1:0] src_a,
  input  logic [REG_ID_WID-1:0] src_b,
  output logic [DATA_WID-1:0]   val_a,
  output logic [DATA_WID-1:0]   val_b
);

  // Highest valid id; anything above it (RNONE) reads as zero and is never written.
  localparam logic [REG_ID_WID-1:0] LAST_ID = REG_ID_WID'(NUM_REGS - 1);

  logic [DATA_WID-1:0] regs [NUM_REGS];

  // Read one port: zero for out-of-range ids, else bypass the in-flight
  // write (M before E), else the stored value.
  function automatic logic [DATA_WID-1:0] read_port(input logic [REG_ID_WID-1:0] src);
    logic [DATA_WID-1:0] data;
    data = '0;
    if (src <= LAST_ID) begin
      if (we_m && dst_m == src)      data = val_m;
      else if (we_e && dst_e == src) data = val_e;
      else                           data = regs[src];
    end
    return data;
  endfunction

  // Storage update: clear everything on reset, otherwise commit enabled writes.
  // NOTE: the storage is reset on purpose because software may read any register after reset and must see 0.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        // NOTE: non-blocking assignments so every register sees pre-edge values, independent of statement order.
        if (we_m && dst_m == REG_ID_WID'(i))      regs[i] <= val_m;
        else if (we_e && dst_e == REG_ID_WID'(i)) regs[i] <= val_e;
      end
    end
  end

  // Combinational read ports.
  // NOTE: each output is assigned on every path through the block, so no latch is inferred.
  always_comb begin
    val_a = read_port(src_a);
    val_b = read_port(src_b);
  end

endmodule

// File: rtl/write_back_stage.sv
// Y86 write-back stage: commits valE/valM into the register file, tracks the
// run/halt/fault state and counts retired instructions.
module write_back_stage
  import write_back_stage_pkg::*;
#(
  parameter int DATA_WID   = DATA_WID_DEF,
  parameter int REG_ID_WID = REG_ID_WID_DEF,
  parameter int NUM_REGS   = NUM_REGS_DEF,
  parameter int CNT_WID    = CNT_WID_DEF
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  wb_valid,
  input  logic [3:0]            icode,
  input  logic [3:0]            stat_in,
  input  logic [REG_ID_WID-1:0] dstE,
  input  logic [REG_ID_WID-1:0] dstM,
  input  logic [DATA_WID-1:0]   valE,
  input  logic [DATA_WID-1:0]   valM,
  input  logic [REG_ID_WID-1:0] srcA,
  input  logic [REG_ID_WID-1:0] srcB,
  output logic [DATA_WID-1:0]   valA_out,
  output logic [DATA_WID-1:0]   valB_out,
  output logic [3:0]            cpu_stat,
  output logic                  halted,
  output logic [CNT_WID-1:0]    retired_cnt
);

  localparam logic [REG_ID_WID-1:0] REG_NONE = '1;

  wb_state_t state;
  logic      run;
  logic      commit;
  logic      we_e;
  logic      we_m;

  // icode is carried for visibility only; commit decisions never look at it.
  logic unused_icode;
  assign unused_icode = ^icode;

  // Writes (and the bypass that mirrors them) happen only for a valid AOK
  // instruction while the processor is running.
  assign run    = (state == WB_RUN);
  assign commit = run && wb_valid && (stat_in == SAOK);
  assign we_e   = commit && (dstE != REG_NONE);
  assign we_m   = commit && (dstM != REG_NONE);

  reg_file #(
    .DATA_WID   (DATA_WID),
    .REG_ID_WID (REG_ID_WID),
    .NUM_REGS   (NUM_REGS)
  ) u_reg_file (
    .CLK   (CLK),
    .RST_N (RST_N),
    .we_e  (we_e),
    .dst_e (dstE),
    .val_e (valE),
    .we_m  (we_m),
    .dst_m (dstM),
    .val_m (valM),
    .src_a (srcA),
    .src_b (srcB),
    .val_a (valA_out),
    .val_b (valB_out)
  );

  // Processor state machine with registered status, halted flag and retire counter.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= WB_RUN;
      cpu_stat    <= SAOK;
      halted      <= 1'b0;
      retired_cnt <= '0;
    end else if (run && wb_valid) begin
      if (stat_in == SAOK) begin
        retired_cnt <= retired_cnt + CNT_WID'(1);
      end else if (stat_in == SHLT) begin
        // halt itself retires, then everything freezes
        retired_cnt <= retired_cnt + CNT_WID'(1);
        cpu_stat    <= SHLT;
        state       <= WB_HALTED;
        halted      <= 1'b1;
      end else begin
        cpu_stat <= fault_code(stat_in);
        state    <= WB_FAULT;
        halted   <= 1'b1;
      end
    end
  end

endmodule
